// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer: stall, jump, relative branch, call/return via a
// circular return-address stack, and a RUN/HALTED state machine.
module pc_seq_ctrl #(
  parameter int PC_WIDTH  = 6,
  parameter int OFF_WIDTH = 6,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_PC  = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               stall,
  input  logic                               jump,
  input  logic [PC_WIDTH-1:0]                jump_target,
  input  logic                               branch,
  input  logic [OFF_WIDTH-1:0]               branch_off,
  input  logic                               call,
  input  logic                               ret,
  input  logic                               halt,
  input  logic                               resume,
  output logic [PC_WIDTH-1:0]                address,
  output logic                               halted,
  output logic                               ras_ovf,
  output logic                               ras_unf,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count
);

  localparam int SP_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH+1);

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;

  function automatic logic [PC_WIDTH-1:0] sext_off(input logic signed [OFF_WIDTH-1:0] off);
    return PC_WIDTH'(off);
  endfunction

  logic [0:0]          r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [SP_W-1:0]     r_sp;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf;
  logic                r_unf;
  logic [PC_WIDTH-1:0] r_ras [RAS_DEPTH];

  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [SP_W-1:0]     w_sp_dec;
  logic                w_run_act;
  logic                w_pop;
  logic                w_push;
  logic                w_full;
  logic                w_empty;

  assign w_pc_inc  = r_pc + PC_WIDTH'(1);
  assign w_sp_dec  = r_sp - SP_W'(1);
  assign w_full    = (r_cnt == CNT_W'(RAS_DEPTH));
  assign w_empty   = (r_cnt == '0);
  // Lower-priority controls are masked here so they never touch the RAS.
  assign w_run_act = (r_state == S_RUN) && !stall && !halt;
  assign w_pop     = w_run_act && ret;
  assign w_push    = w_run_act && !ret && call;

  // r_sp always points at the next free slot; when full that slot is the oldest.
  always_ff @(posedge clk) begin
    if (!rst && w_push)
      r_ras[r_sp] <= w_pc_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_pc    <= PC_WIDTH'(RESET_PC);
      r_sp    <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (r_state == S_HALTED) begin
      if (resume) begin
        r_state <= S_RUN;
        r_pc    <= w_pc_inc;
      end
    end else if (!stall) begin
      if (halt) begin
        r_state <= S_HALTED;
      end else if (w_pop) begin
        if (w_empty) begin
          r_pc  <= w_pc_inc;
          r_unf <= 1'b1;
        end else begin
          r_pc  <= r_ras[w_sp_dec];
          r_sp  <= w_sp_dec;
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end else if (w_push) begin
        r_pc <= jump_target;
        r_sp <= r_sp + SP_W'(1);
        if (w_full)
          r_ovf <= 1'b1;
        else
          r_cnt <= r_cnt + CNT_W'(1);
      end else if (jump) begin
        r_pc <= jump_target;
      end else if (branch) begin
        r_pc <= r_pc + sext_off(branch_off);
      end else begin
        r_pc <= w_pc_inc;
      end
    end
  end

  assign address   = r_pc;
  assign halted    = r_state;
  assign ras_ovf   = r_ovf;
  assign ras_unf   = r_unf;
  assign ras_count = r_cnt;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed scenarios plus randomized control traffic
// checked against a queue-based reference model of the sequencer.
module tb_pc_seq_ctrl;

  localparam int PW    = 6;
  localparam int OW    = 6;
  localparam int DEPTH = 4;
  localparam int RPC   = 0;
  localparam int MODV  = 1 << PW;

  logic          clk = 1'b0;
  logic          rst, stall, jump, branch, call, ret, halt, resume;
  logic [PW-1:0] jump_target;
  logic [OW-1:0] branch_off;
  logic [PW-1:0] address;
  logic          halted, ras_ovf, ras_unf;
  logic [2:0]    ras_count;

  int n_vec = 0;
  int n_err = 0;

  int m_pc;
  bit m_halt, m_ovf, m_unf;
  int m_ras[$];

  always #5 clk = ~clk;

  pc_seq_ctrl #(.PC_WIDTH(PW), .OFF_WIDTH(OW), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jump(jump), .jump_target(jump_target),
    .branch(branch), .branch_off(branch_off), .call(call), .ret(ret), .halt(halt),
    .resume(resume), .address(address), .halted(halted), .ras_ovf(ras_ovf),
    .ras_unf(ras_unf), .ras_count(ras_count)
  );

  task automatic clr();
    rst = 0; stall = 0; jump = 0; branch = 0; call = 0; ret = 0; halt = 0; resume = 0;
    jump_target = '0; branch_off = '0;
  endtask

  task automatic model_next();
    int off;
    if (rst) begin
      m_pc = RPC; m_halt = 0; m_ovf = 0; m_unf = 0; m_ras.delete();
    end else if (m_halt) begin
      if (resume) begin m_halt = 0; m_pc = (m_pc + 1) % MODV; end
    end else if (stall) begin
    end else if (halt) begin
      m_halt = 1;
    end else if (ret) begin
      if (m_ras.size() == 0) begin m_pc = (m_pc + 1) % MODV; m_unf = 1; end
      else m_pc = m_ras.pop_back();
    end else if (call) begin
      if (m_ras.size() == DEPTH) begin void'(m_ras.pop_front()); m_ovf = 1; end
      m_ras.push_back((m_pc + 1) % MODV);
      m_pc = int'(jump_target);
    end else if (jump) begin
      m_pc = int'(jump_target);
    end else if (branch) begin
      off = int'(branch_off);
      if (off >= (1 << (OW - 1))) off -= (1 << OW);
      m_pc = ((m_pc + off) % MODV + MODV) % MODV;
    end else begin
      m_pc = (m_pc + 1) % MODV;
    end
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr(); rst = 1; step(); rst = 0;
  endtask

  task automatic test_reset();
    clr(); jump = 1; jump_target = 6'd33; step(); step();
    do_reset();
    n_vec++; if (address !== 6'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", address); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_vec++; if (ras_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", ras_count); end
    n_vec++; if ({ras_ovf, ras_unf} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b%b want 00", ras_ovf, ras_unf); end
  endtask

  task automatic test_free_run();
    do_reset();
    for (int i = 0; i < 70; i++) begin
      n_vec++; if (address !== PW'(i % MODV)) begin n_err++; $display("FAIL free_run[%0d]: got %0d want %0d", i, address, i % MODV); end
      n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL free_run_halted[%0d]: got %b want 0", i, halted); end
      step();
    end
  endtask

  task automatic test_branch();
    clr(); jump = 1; jump_target = 6'd10; step(); clr();
    branch = 1; branch_off = 6'b111100; step(); clr();
    n_vec++; if (address !== 6'd6) begin n_err++; $display("FAIL branch_back: got %0d want 6", address); end
    jump = 1; jump_target = 6'd2; step(); clr();
    branch = 1; branch_off = 6'b111100; step(); clr();
    n_vec++; if (address !== 6'd62) begin n_err++; $display("FAIL branch_wrap: got %0d want 62", address); end
    branch = 1; branch_off = 6'd5; step(); clr();
    n_vec++; if (address !== 6'd3) begin n_err++; $display("FAIL branch_fwd_wrap: got %0d want 3", address); end
  endtask

  task automatic test_call_ret();
    do_reset();
    jump = 1; jump_target = 6'd5; step(); clr();
    call = 1; jump_target = 6'd40; step(); clr();
    n_vec++; if (address !== 6'd40) begin n_err++; $display("FAIL call_addr: got %0d want 40", address); end
    n_vec++; if (ras_count !== 3'd1) begin n_err++; $display("FAIL call_count: got %0d want 1", ras_count); end
    step(); step();
    ret = 1; step(); clr();
    n_vec++; if (address !== 6'd6) begin n_err++; $display("FAIL ret_addr: got %0d want 6", address); end
    n_vec++; if (ras_count !== 3'd0) begin n_err++; $display("FAIL ret_count: got %0d want 0", ras_count); end
    jump = 1; jump_target = 6'd63; step(); clr();
    call = 1; jump_target = 6'd7; step(); clr();
    ret = 1; step(); clr();
    n_vec++; if (address !== 6'd0) begin n_err++; $display("FAIL call_top_push: got %0d want 0", address); end
  endtask

  task automatic test_nested();
    int exp_ret[4] = '{41, 31, 21, 11};
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      call = 1; jump_target = PW'(10 * k); step(); clr();
    end
    n_vec++; if (address !== 6'd50) begin n_err++; $display("FAIL nest_addr: got %0d want 50", address); end
    n_vec++; if (ras_ovf !== 1'b1) begin n_err++; $display("FAIL nest_ovf: got %b want 1", ras_ovf); end
    n_vec++; if (ras_count !== 3'd4) begin n_err++; $display("FAIL nest_count: got %0d want 4", ras_count); end
    for (int k = 0; k < 4; k++) begin
      ret = 1; step(); clr();
      n_vec++; if (address !== PW'(exp_ret[k])) begin n_err++; $display("FAIL nest_ret[%0d]: got %0d want %0d", k, address, exp_ret[k]); end
    end
    n_vec++; if (ras_unf !== 1'b0) begin n_err++; $display("FAIL nest_unf_early: got %b want 0", ras_unf); end
    ret = 1; step(); clr();
    n_vec++; if (address !== 6'd12) begin n_err++; $display("FAIL unf_addr: got %0d want 12", address); end
    n_vec++; if (ras_unf !== 1'b1) begin n_err++; $display("FAIL unf_flag: got %b want 1", ras_unf); end
    n_vec++; if (ras_count !== 3'd0) begin n_err++; $display("FAIL unf_count: got %0d want 0", ras_count); end
  endtask

  task automatic test_stall_halt();
    do_reset();
    jump = 1; jump_target = 6'd20; step(); clr();
    for (int k = 0; k < 3; k++) begin
      stall = 1; jump = 1; jump_target = 6'd50; call = (k == 1); step(); clr();
      n_vec++; if (address !== 6'd20) begin n_err++; $display("FAIL stall_addr[%0d]: got %0d want 20", k, address); end
      n_vec++; if (ras_count !== 3'd0) begin n_err++; $display("FAIL stall_count[%0d]: got %0d want 0", k, ras_count); end
    end
    halt = 1; resume = 1; step(); clr();
    n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_enter: got %b want 1", halted); end
    n_vec++; if (address !== 6'd20) begin n_err++; $display("FAIL halt_addr: got %0d want 20", address); end
    for (int k = 0; k < 3; k++) begin
      jump = (k != 1); call = (k == 1); jump_target = 6'd50; step(); clr();
      n_vec++; if (address !== 6'd20 || halted !== 1'b1) begin n_err++; $display("FAIL halt_hold[%0d]: got addr %0d halted %b want 20/1", k, address, halted); end
    end
    n_vec++; if (ras_count !== 3'd0) begin n_err++; $display("FAIL halt_count: got %0d want 0", ras_count); end
    resume = 1; step(); clr();
    n_vec++; if (address !== 6'd21) begin n_err++; $display("FAIL resume_addr: got %0d want 21", address); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL resume_halted: got %b want 0", halted); end
  endtask

  task automatic test_reset_halted();
    do_reset();
    ret = 1; step(); clr();
    for (int k = 0; k < 5; k++) begin call = 1; jump_target = PW'(8 + k); step(); clr(); end
    ret = 1; step(); clr();
    halt = 1; step(); clr();
    n_vec++; if ({halted, ras_count, ras_ovf, ras_unf} !== {1'b1, 3'd3, 2'b11})
      begin n_err++; $display("FAIL pre_reset_state: got h%b c%0d f%b%b want h1 c3 f11", halted, ras_count, ras_ovf, ras_unf); end
    rst = 1; resume = 1; call = 1; step(); clr();
    n_vec++; if (address !== PW'(RPC)) begin n_err++; $display("FAIL rst_halt_addr: got %0d want %0d", address, RPC); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halt_halted: got %b want 0", halted); end
    n_vec++; if (ras_count !== 3'd0) begin n_err++; $display("FAIL rst_halt_count: got %0d want 0", ras_count); end
    n_vec++; if ({ras_ovf, ras_unf} !== 2'b00) begin n_err++; $display("FAIL rst_halt_flags: got %b%b want 00", ras_ovf, ras_unf); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 7) == 0);
      halt = ($urandom_range(0, 15) == 0);
      resume = ($urandom_range(0, 3) == 0);
      ret = ($urandom_range(0, 5) == 0);
      call = ($urandom_range(0, 4) == 0);
      jump = ($urandom_range(0, 5) == 0);
      branch = ($urandom_range(0, 2) == 0);
      jump_target = PW'($urandom);
      branch_off = OW'($urandom);
      step();
      n_vec++; if (address !== PW'(m_pc)) begin n_err++; $display("FAIL rnd_addr[%0d]: got %0d want %0d", i, address, m_pc); end
      n_vec++; if (halted !== m_halt) begin n_err++; $display("FAIL rnd_halted[%0d]: got %b want %b", i, halted, m_halt); end
      n_vec++; if (ras_count !== 3'(m_ras.size())) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, ras_count, m_ras.size()); end
      n_vec++; if ({ras_ovf, ras_unf} !== {m_ovf, m_unf}) begin n_err++; $display("FAIL rnd_flags[%0d]: got %b%b want %b%b", i, ras_ovf, ras_unf, m_ovf, m_unf); end
    end
    clr();
  endtask

  initial begin
    clr();
    test_reset();
    test_free_run();
    test_branch();
    test_call_ret();
    test_nested();
    test_stall_halt();
    test_reset_halted();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Parametrised program-counter sequencer for the single-cycle CPU; generalises the free-running 6-bit instruction counter.
- Adds stall, absolute jump, PC-relative branch, call/return through an internal return-address stack (RAS), and a halt state.
- Drives the instruction-memory address directly; control inputs come from the decode/branch logic in the same cycle.

Parameters:
- PC_WIDTH, 6, address width in bits; PC wraps modulo 2^PC_WIDTH.
- OFF_WIDTH, 6, width of the signed branch offset (two's complement, sign-extended to PC_WIDTH).
- RAS_DEPTH, 4, number of return-address stack entries (power of two, >=2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and RAS this cycle.
- jump  in  1  load jump_target.
- jump_target  in  PC_WIDTH  absolute target.
- branch  in  1  branch taken; add branch_off to PC.
- branch_off  in  OFF_WIDTH  signed offset relative to current PC.
- call  in  1  push PC+1, then load jump_target.
- ret  in  1  pop RAS into PC.
- halt  in  1  enter HALTED state.
- resume  in  1  leave HALTED, continue at held PC+1.
- address  out  PC_WIDTH  current PC, registered.
- halted  out  1  high in HALTED state.
- ras_ovf  out  1  sticky; a call occurred with the RAS full.
- ras_unf  out  1  sticky; a ret occurred with the RAS empty.
- ras_count  out  $clog2(RAS_DEPTH+1)  current RAS occupancy.

Behaviour:
- Reset (clk edge with rst=1): address=RESET_PC, state RUN, halted=0, RAS emptied (ras_count=0), ras_ovf=0, ras_unf=0. Reset overrides every other input, including in HALTED and mid-stall.
- The FSM has two states, RUN and HALTED.
  - RUN→HALTED when halt=1 and stall=0; address is unchanged on that edge.
  - HALTED→RUN when resume=1; address becomes address+1 on that edge.
  - In HALTED, all other control inputs are ignored.
  - halt and resume asserted together in RUN: halt wins.
- Next-PC priority in RUN, all registered with 1-cycle latency. Multiple asserted controls are legal; the highest priority wins, and lower ones have no effect (no RAS side effects).
  1. stall: address, RAS and flags hold.
  2. halt: as described for the FSM.
  3. ret: address = RAS top; pop.
  4. call: push address+1 (mod 2^PC_WIDTH); address = jump_target.
  5. jump: address = jump_target.
  6. branch: address = address + sign_extend(branch_off), mod 2^PC_WIDTH.
  7. default: address = address+1.
- Wrap-around:
  - all arithmetic is truncated to PC_WIDTH; address 2^PC_WIDTH-1 increments to 0;
  - a negative branch offset below 0 wraps high;
  - call at the top address pushes 0.
- RAS overflow: call with ras_count==RAS_DEPTH overwrites the oldest entry (circular), ras_count stays RAS_DEPTH, ras_ovf is set, and the jump still happens.
- RAS underflow: ret with ras_count==0 gives address=address+1, ras_count stays 0, and ras_unf is set.
- ras_ovf and ras_unf clear only on reset.
- Outputs come directly from registers; there is no combinational path from inputs to outputs.

Test Plan:
- Reset then 70 free-run cycles (PC_WIDTH=6) -> address 0,1,…,63,0,…,5; halted=0.
- address=10, branch=1, branch_off=6'b111100 (-4) -> address 6 next cycle; at address=2 with off=-4 -> address 62.
- address=5, call=1, jump_target=40 -> address 40, ras_count=1; 3 cycles later ret=1 -> address 6, ras_count=0.
- Five nested calls with RAS_DEPTH=4 -> ras_ovf=1, ras_count=4; then five rets -> the first four return the correct addresses in LIFO order, the fifth gives address+1 and sets ras_unf=1.
- At address=20: stall=1 together with jump=1 for 3 cycles -> address stays 20 with no RAS change; then halt=1 -> halted=1, address 20 held while jump pulses; resume=1 -> address 21, halted=0.
- rst asserted in HALTED with ras_count=3 and both flags set -> next cycle address=RESET_PC, halted=0, ras_count=0, flags=0.
